// File: rtl/ex_operand_stage.sv
// ex_operand_stage: one-entry EX operand buffer with bypass forwarding and load-use interlock.
// Build option EX_FWD_EN enables forwarding; when undefined, any pending producer match interlocks.
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [9:0]  in_rs_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [7:0]  in_ctrl,
  input  logic        flush,
  input  logic        mem_fwd_valid,
  input  logic        mem_fwd_is_load,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_valid,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  output logic [3:0]  alu_sel,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd_addr,
  output logic [1:0]  out_ctrl
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HELD   = 2'd1,
    ST_HAZARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd;
  logic [7:0]  r_ctrl;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;
  logic [31:0] w_inp2;
  logic        w_stall;
  logic        w_held;
  logic        w_capture;
  logic        w_consume;

  function automatic logic hit(input logic [4:0] src, input logic en, input logic [4:0] rd);
    hit = en && (src != 5'd0) && (src == rd);
  endfunction

`ifdef EX_FWD_EN
  function automatic logic [31:0] fwd_sel(input logic [4:0] src, input logic [31:0] held,
                                          input logic mem_en, input logic [4:0] mem_rd,
                                          input logic [31:0] mem_data, input logic wb_en,
                                          input logic [4:0] wb_rd, input logic [31:0] wb_data);
    if (hit(src, mem_en, mem_rd)) begin
      fwd_sel = mem_data;
    end else if (hit(src, wb_en, wb_rd)) begin
      fwd_sel = wb_data;
    end else begin
      fwd_sel = held;
    end
  endfunction

  // A load in EX/MEM cannot be bypassed yet, so only that case stalls.
  always_comb begin
    w_stall   = hit(r_rs1_addr, mem_fwd_valid & mem_fwd_is_load, mem_fwd_rd) |
                hit(r_rs2_addr, mem_fwd_valid & mem_fwd_is_load, mem_fwd_rd);
    w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1, mem_fwd_valid & ~mem_fwd_is_load, mem_fwd_rd,
                        mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2, mem_fwd_valid & ~mem_fwd_is_load, mem_fwd_rd,
                        mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{mem_fwd_is_load, mem_fwd_data, wb_fwd_data};

  always_comb begin
    w_stall   = hit(r_rs1_addr, mem_fwd_valid, mem_fwd_rd) | hit(r_rs1_addr, wb_fwd_valid, wb_fwd_rd) |
                hit(r_rs2_addr, mem_fwd_valid, mem_fwd_rd) | hit(r_rs2_addr, wb_fwd_valid, wb_fwd_rd);
    w_fwd_rs1 = r_rs1;
    w_fwd_rs2 = r_rs2;
  end
`endif

  assign w_held    = (r_state != ST_EMPTY);
  assign out_valid = w_held & ~w_stall;
  assign in_ready  = (r_state == ST_EMPTY) | (out_valid & out_ready);
  assign w_capture = in_valid & in_ready & ~flush;
  assign w_consume = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_capture) w_state_nxt = ST_HELD;
          else           w_state_nxt = ST_EMPTY;
        end
        ST_HELD, ST_HAZARD: begin
          if (w_capture)      w_state_nxt = ST_HELD;
          else if (w_consume) w_state_nxt = ST_EMPTY;
          else if (w_stall)   w_state_nxt = ST_HAZARD;
          else                w_state_nxt = ST_HELD;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held operands absorb forwarded values so a bypass survives the producer retiring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= 32'd0;
      r_rs1      <= 32'd0;
      r_rs2      <= 32'd0;
      r_imm      <= 32'd0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rd       <= 5'd0;
      r_ctrl     <= 8'd0;
    end else if (w_capture) begin
      r_pc       <= in_pc;
      r_rs1      <= in_rs1_data;
      r_rs2      <= in_rs2_data;
      r_imm      <= in_imm;
      r_rs1_addr <= in_rs_addr[4:0];
      r_rs2_addr <= in_rs_addr[9:5];
      r_rd       <= in_rd_addr;
      r_ctrl     <= in_ctrl;
    end else if (w_held && !w_consume && !flush) begin
      r_rs1 <= w_fwd_rs1;
      r_rs2 <= w_fwd_rs2;
    end
  end

  assign alu_inp1       = r_ctrl[4] ? r_pc : w_fwd_rs1;
  assign w_inp2         = r_ctrl[5] ? r_imm : w_fwd_rs2;
  assign out_store_data = w_fwd_rs2;
  assign alu_sel        = r_ctrl[3:0];
  assign out_rd_addr    = r_rd;
  assign out_ctrl       = r_ctrl[7:6];

  // Shift opcodes only consume a 5-bit shift amount.
  always_comb begin
    case (r_ctrl[3:0])
      4'b0100, 4'b0101, 4'b1001, 4'b1010: alu_inp2 = {27'd0, w_inp2[4:0]};
      default:                            alu_inp2 = w_inp2;
    endcase
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, hand-written corner sequences and a
// randomized run against a record-level model of the held instruction.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [9:0]  in_rs_addr;
  logic [4:0]  in_rd_addr;
  logic [7:0]  in_ctrl;
  logic        flush;
  logic        mem_fwd_valid;
  logic        mem_fwd_is_load;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_inp1;
  logic [31:0] alu_inp2;
  logic [3:0]  alu_sel;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic [1:0]  out_ctrl;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs_addr(in_rs_addr), .in_rd_addr(in_rd_addr), .in_ctrl(in_ctrl), .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_is_load(mem_fwd_is_load), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_sel(alu_sel),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, pc, imm;
    logic [7:0]  ctrl;
    logic        mv, ml;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        ev_f, ev_n;
    logic [31:0] e1_f, e2_f, e1_n, e2_n;
  } vec_t;

  vec_t vecs[11];

  // model of the held instruction
  bit          m_v;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [7:0]  m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0;
    in_rs_addr = 10'd0; in_rd_addr = 5'd0; in_ctrl = 8'd0; flush = 1'b0; out_ready = 1'b0;
    mem_fwd_valid = 1'b0; mem_fwd_is_load = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic instr(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [7:0] ctrl, input logic [4:0] rd);
    in_rs_addr = {a2, a1}; in_rs1_data = d1; in_rs2_data = d2; in_pc = pc; in_imm = imm;
    in_ctrl = ctrl; in_rd_addr = rd;
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] held);
    if (!FWD || src == 5'd0) return held;
    if (mem_fwd_valid && !mem_fwd_is_load && mem_fwd_rd == src) return mem_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == src) return wb_fwd_data;
    return held;
  endfunction

  function automatic bit m_blocks(input logic [4:0] src);
    if (src == 5'd0) return 1'b0;
    if (mem_fwd_valid && mem_fwd_rd == src && (mem_fwd_is_load || !FWD)) return 1'b1;
    if (!FWD && wb_fwd_valid && wb_fwd_rd == src) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    vecs[0]  = '{5'd5, 5'd6, 32'h111, 32'h222, 32'h0, 32'h0, 8'h40, 1'b1, 1'b0, 5'd5, 32'h10,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h222, 32'h111, 32'h222};
    vecs[1]  = '{5'd1, 5'd7, 32'h1, 32'h2, 32'h0, 32'h0, 8'h40, 1'b1, 1'b0, 5'd7, 32'hA,
                 1'b1, 5'd7, 32'hB, 1'b1, 1'b0, 32'h1, 32'hA, 32'h1, 32'h2};
    vecs[2]  = '{5'd0, 5'd0, 32'h33, 32'h44, 32'h0, 32'h0, 8'h40, 1'b1, 1'b0, 5'd0, 32'h55,
                 1'b1, 5'd0, 32'h66, 1'b1, 1'b1, 32'h33, 32'h44, 32'h33, 32'h44};
    vecs[3]  = '{5'd2, 5'd3, 32'hABCD, 32'hFFFFFF23, 32'h0, 32'h0, 8'h04, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hABCD, 32'h3, 32'hABCD, 32'h3};
    vecs[4]  = '{5'd2, 5'd3, 32'hABCD, 32'h5, 32'h1000, 32'hFFFFFFFF, 8'h3A, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h1F, 32'h1000, 32'h1F};
    vecs[5]  = '{5'd2, 5'd3, 32'h77, 32'h5, 32'h0, 32'hFFFFF800, 8'h23, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h77, 32'hFFFFF800, 32'h77, 32'hFFFFF800};
    vecs[6]  = '{5'd3, 5'd4, 32'h30, 32'h44, 32'h0, 32'h0, 8'h40, 1'b1, 1'b1, 5'd4, 32'hDEAD,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h30, 32'h44, 32'h30, 32'h44};
    vecs[7]  = '{5'd9, 5'd10, 32'h90, 32'hA0, 32'h0, 32'h0, 8'h40, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 5'd9, 32'h900, 1'b1, 1'b0, 32'h900, 32'hA0, 32'h90, 32'hA0};
    vecs[8]  = '{5'd9, 5'd10, 32'h90, 32'hA0, 32'h0, 32'h0, 8'h40, 1'b0, 1'b0, 5'd9, 32'hBAD,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h90, 32'hA0, 32'h90, 32'hA0};
    vecs[9]  = '{5'd1, 5'd6, 32'h11, 32'h12345678, 32'h0, 32'h0, 8'h05, 1'b1, 1'b0, 5'd6, 32'hFFFFFFE7,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h11, 32'h7, 32'h11, 32'h18};
    vecs[10] = '{5'd1, 5'd2, 32'h11, 32'h41, 32'h2000, 32'h0, 8'h19, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1, 32'h2000, 32'h1};

    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_out_ctrl", {30'd0, out_ctrl}, 32'd0);
    chk("rst_rd", {27'd0, out_rd_addr}, 32'd0);
    chk("rst_inp1", alu_inp1, 32'd0);
    chk("rst_inp2", alu_inp2, 32'd0);
    chk("rst_store", out_store_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed table: capture, then present forwarding sources while held
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle();
      instr(vecs[i].rs1a, vecs[i].rs2a, vecs[i].rs1d, vecs[i].rs2d, vecs[i].pc, vecs[i].imm,
            vecs[i].ctrl, 5'd1);
      in_valid = 1'b1;
      @(negedge clk);
      idle();
      mem_fwd_valid = vecs[i].mv; mem_fwd_is_load = vecs[i].ml;
      mem_fwd_rd = vecs[i].mrd; mem_fwd_data = vecs[i].mdat;
      wb_fwd_valid = vecs[i].wv; wb_fwd_rd = vecs[i].wrd; wb_fwd_data = vecs[i].wdat;
      #2;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, FWD ? vecs[i].ev_f : vecs[i].ev_n});
      chk($sformatf("vec%0d_inp1", i), alu_inp1, FWD ? vecs[i].e1_f : vecs[i].e1_n);
      chk($sformatf("vec%0d_inp2", i), alu_inp2, FWD ? vecs[i].e2_f : vecs[i].e2_n);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      idle();
      flush = 1'b1;
    end

    // load-use stall, then writeback bypass, then persistence after the producer leaves
    @(negedge clk);
    idle();
    instr(5'd1, 5'd3, 32'h10, 32'h5, 32'h0, 32'h0, 8'h40, 5'd8);
    in_valid = 1'b1;
    @(negedge clk);
    idle();
    mem_fwd_valid = 1'b1; mem_fwd_is_load = 1'b1; mem_fwd_rd = 5'd3;
    #2;
    chk("ld_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("ld_stall_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    idle();
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h99;
    #2;
    chk("ld_wb_valid", {31'd0, out_valid}, FWD ? 32'd1 : 32'd0);
    chk("ld_wb_inp2", alu_inp2, FWD ? 32'h99 : 32'h5);
    @(negedge clk);
    idle();
    #2;
    chk("ld_persist_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_persist_inp2", alu_inp2, FWD ? 32'h99 : 32'h5);
    chk("ld_persist_store", out_store_data, FWD ? 32'h99 : 32'h5);
    chk("ld_rd", {27'd0, out_rd_addr}, 32'd8);
    chk("ld_ctrl", {30'd0, out_ctrl}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("consume_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idle();
    #2;
    chk("after_consume_valid", {31'd0, out_valid}, 32'd0);

    // flush beats a simultaneous in_valid
    @(negedge clk);
    idle();
    instr(5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h0, 8'h40, 5'd4);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    idle();
    #2;
    chk("flush_cap_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_cap_ready", {31'd0, in_ready}, 32'd1);

    // consume and capture in one cycle: no bubble
    @(negedge clk);
    idle();
    instr(5'd1, 5'd2, 32'h111, 32'h2, 32'h0, 32'h0, 8'h40, 5'd1);
    in_valid = 1'b1;
    @(negedge clk);
    instr(5'd1, 5'd2, 32'h222, 32'h2, 32'h0, 32'h0, 8'h80, 5'd2);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    idle();
    #2;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_rd", {27'd0, out_rd_addr}, 32'd2);
    chk("b2b_inp1", alu_inp1, 32'h222);
    chk("b2b_ctrl", {30'd0, out_ctrl}, 32'd2);

    // asynchronous reset in the middle of a hazard
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(negedge clk);
    idle();
    instr(5'd4, 5'd0, 32'h44, 32'h0, 32'h0, 32'h0, 8'h45, 5'd3);
    in_valid = 1'b1;
    @(negedge clk);
    idle();
    mem_fwd_valid = 1'b1; mem_fwd_is_load = 1'b1; mem_fwd_rd = 5'd4;
    #2;
    chk("hz_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    #1;
    chk("hz_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("hz_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("hz_rst_sel", {28'd0, alu_sel}, 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    m_v = 1'b0;

    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] f1, f2, b;
      bit          e_valid, e_ready;
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom, $urandom, 8'($urandom), 5'($urandom));
      flush = ($urandom_range(0, 15) == 0);
      out_ready = 1'($urandom_range(0, 1));
      mem_fwd_valid = 1'($urandom_range(0, 1));
      mem_fwd_is_load = ($urandom_range(0, 3) == 0);
      mem_fwd_rd = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_fwd_valid = 1'($urandom_range(0, 1));
      wb_fwd_rd = 5'($urandom_range(0, 3));
      wb_fwd_data = $urandom;
      #2;
      f1 = m_fwd(m_a1, m_rs1);
      f2 = m_fwd(m_a2, m_rs2);
      e_valid = m_v && !m_blocks(m_a1) && !m_blocks(m_a2);
      e_ready = !m_v || (e_valid && out_ready);
      chk($sformatf("rnd%0d_valid", c), {31'd0, out_valid}, {31'd0, e_valid});
      chk($sformatf("rnd%0d_ready", c), {31'd0, in_ready}, {31'd0, e_ready});
      if (m_v) begin
        b = m_ctrl[5] ? m_imm : f2;
        if (m_ctrl[3:0] == 4'd4 || m_ctrl[3:0] == 4'd5 || m_ctrl[3:0] == 4'd9 || m_ctrl[3:0] == 4'd10)
          b = b % 32'd32;
        chk($sformatf("rnd%0d_inp1", c), alu_inp1, m_ctrl[4] ? m_pc : f1);
        chk($sformatf("rnd%0d_inp2", c), alu_inp2, b);
        chk($sformatf("rnd%0d_store", c), out_store_data, f2);
        chk($sformatf("rnd%0d_sel", c), {28'd0, alu_sel}, {28'd0, m_ctrl[3:0]});
        chk($sformatf("rnd%0d_rd", c), {27'd0, out_rd_addr}, {27'd0, m_rd});
        chk($sformatf("rnd%0d_ctrl", c), {30'd0, out_ctrl}, {30'd0, m_ctrl[7:6]});
      end
      @(posedge clk);
      if (flush) begin
        m_v = 1'b0;
      end else if (in_valid && e_ready) begin
        m_v = 1'b1; m_pc = in_pc; m_rs1 = in_rs1_data; m_rs2 = in_rs2_data; m_imm = in_imm;
        m_a1 = in_rs_addr[4:0]; m_a2 = in_rs_addr[9:5]; m_rd = in_rd_addr; m_ctrl = in_ctrl;
      end else if (e_valid && out_ready) begin
        m_v = 1'b0;
      end else if (m_v) begin
        m_rs1 = f1; m_rs2 = f2;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
